// File: rtl/kernel_axi_mem_slave.sv
// AXI4 INCR-burst memory target (AW/W/B/AR/R, no IDs) backed by a word-addressed RAM.
// Define KERNEL_AXI_MEM_SLAVE_PROTOCOL_CHECK_EN to enable the sticky prot_err checker.
module kernel_axi_mem_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH_LOG2   = 8
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            prot_err
);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int DL    = C_MEM_DEPTH_LOG2;
  localparam int BW    = DW / 8;
  localparam int OFF   = $clog2(BW);
  localparam int DEPTH = 1 << DL;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [DW-1:0] mem [DEPTH];

  logic          live;
  wstate_t       w_state, w_next;
  rstate_t       r_state, r_next;
  logic [DL-1:0] w_idx, r_idx, aw_idx, ar_idx;
  logic [7:0]    w_len, w_cnt, r_len, r_cnt;
  logic [DW-1:0] rdata_q;
  logic          aw_fire, w_fire, ar_fire, r_fire, w_last_beat, r_last_beat;

  assign aw_idx      = s_axi_awaddr[OFF +: DL];
  assign ar_idx      = s_axi_araddr[OFF +: DL];
  assign aw_fire     = s_axi_awvalid && s_axi_awready;
  assign w_fire      = s_axi_wvalid && s_axi_wready;
  assign ar_fire     = s_axi_arvalid && s_axi_arready;
  assign r_fire      = s_axi_rvalid && s_axi_rready;
  assign w_last_beat = (w_cnt == w_len);
  assign r_last_beat = (r_cnt == r_len);

  // Keeps address readies low during reset and until the first edge after release.
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) live <= 1'b0;
    else           live <= 1'b1;

  // ---------------- write channel ----------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
    end else begin
      w_state <= w_next;
      if (aw_fire) begin
        w_idx <= aw_idx;
        w_len <= s_axi_awlen;
        w_cnt <= '0;
      end else if (w_fire) begin
        w_idx <= w_idx + DL'(1);
        w_cnt <= w_cnt + 8'd1;
      end
    end
  end

  // Beat count, not wlast, decides when the burst ends.
  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = live;
        if (live && s_axi_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // RAM has no reset so contents survive ap_rst_n.
  always_ff @(posedge ap_clk)
    if (w_fire)
      for (int b = 0; b < BW; b++)
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];

  // ---------------- read channel ----------------
  // rdata is prefetched one beat ahead; a same-cycle write to that word is not seen.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      rdata_q <= '0;
    end else begin
      r_state <= r_next;
      if (ar_fire) begin
        r_idx   <= ar_idx;
        r_len   <= s_axi_arlen;
        r_cnt   <= '0;
        rdata_q <= mem[ar_idx];
      end else if (r_fire && !r_last_beat) begin
        r_idx   <= r_idx + DL'(1);
        r_cnt   <= r_cnt + 8'd1;
        rdata_q <= mem[r_idx + DL'(1)];
      end
    end
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = live;
        if (live && s_axi_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready && r_last_beat) r_next = R_IDLE;
      end
    endcase
  end

  assign s_axi_rdata = rdata_q;
  assign s_axi_rlast = (r_state == R_DATA) && r_last_beat;

`ifdef KERNEL_AXI_MEM_SLAVE_PROTOCOL_CHECK_EN
  logic prot_q, aw_wrap, ar_wrap, wlast_bad;
  logic unused_bits;

  assign aw_wrap   = ((DL+9)'(aw_idx) + (DL+9)'(s_axi_awlen)) >= (DL+9)'(DEPTH);
  assign ar_wrap   = ((DL+9)'(ar_idx) + (DL+9)'(s_axi_arlen)) >= (DL+9)'(DEPTH);
  assign wlast_bad = s_axi_wlast != w_last_beat;

  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) prot_q <= 1'b0;
    else if ((aw_fire && aw_wrap) || (ar_fire && ar_wrap) || (w_fire && wlast_bad))
      prot_q <= 1'b1;

  assign prot_err    = prot_q;
  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr};
`else
  logic unused_bits;
  assign prot_err    = 1'b0;
  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wlast};
`endif

endmodule
